ps2_key_decoder: RTL



---
 rtl/ps2_key_decoder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//
// Receives PS/2 keyboard frames (scan code set 2), reassembles bytes and
// turns make codes of the game control keys into single-cycle pulses.
// Break sequences (F0 xx) and unrecognised codes produce no key pulse.
// Framing problems (parity, stop bit, mid-frame timeout) are flagged.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_dat     raw PS/2 data pin (asynchronous)
//   scan_code   last byte received with correct framing (held)
//   code_valid  one-cycle pulse when scan_code updates
//   frame_error one-cycle pulse on parity error, stop-bit error or timeout
//   key_up/key_down/key_left/key_right  one-cycle make pulses (E0-prefixed)
//   num_1/num_2/num_3/esc               one-cycle make pulses (unprefixed)
//
// Output protocol: there is no valid/ready handshake and no backpressure.
// Every output pulse is registered, lasts exactly one clk cycle and appears
// in the cycle after the stop-bit falling edge is detected; the consumer
// must sample every cycle. At most one key pulse is high in any cycle.
module ps2_key_decoder #(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_error,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       num_1,
  output logic       num_2,
  output logic       num_3,
  output logic       esc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state;
  logic        clk_s1, clk_s2, clk_s3;
  logic        dat_s1, dat_s2;
  logic        fall;
  logic [7:0]  shreg;
  logic [2:0]  bit_cnt;
  logic        parity;
  logic [15:0] to_cnt;
  logic        ext;
  logic        brk;
  logic        byte_good;

  // Synchronisers reset high (idle bus level) so leaving reset never
  // manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

  // Valid only while in STOP on a falling edge: stop bit high and odd
  // parity over data plus parity bit.
  assign byte_good = dat_s2 & ((^shreg) ^ parity);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      parity      <= 1'b0;
      to_cnt      <= 16'd0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      scan_code   <= 8'h00;
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
      key_up      <= 1'b0;
      key_down    <= 1'b0;
      key_left    <= 1'b0;
      key_right   <= 1'b0;
      num_1       <= 1'b0;
      num_2       <= 1'b0;
      num_3       <= 1'b0;
      esc         <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
      key_up      <= 1'b0;
      key_down    <= 1'b0;
      key_left    <= 1'b0;
      key_right   <= 1'b0;
      num_1       <= 1'b0;
      num_2       <= 1'b0;
      num_3       <= 1'b0;
      esc         <= 1'b0;

      // A falling edge always beats the timeout in the same cycle.
      if (fall) begin
        to_cnt <= 16'd0;
        unique case (state)
          IDLE: begin
            // A high sample here is a glitch, not a start bit.
            if (!dat_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity <= dat_s2;
            state  <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (byte_good) begin
              scan_code  <= shreg;
              code_valid <= 1'b1;
              if (shreg == 8'hE0) begin
                ext <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (!brk) begin
                  key_up    <=  ext & (shreg == 8'h75);
                  key_down  <=  ext & (shreg == 8'h72);
                  key_left  <=  ext & (shreg == 8'h6B);
                  key_right <=  ext & (shreg == 8'h74);
                  num_1     <= ~ext & (shreg == 8'h16);
                  num_2     <= ~ext & (shreg == 8'h1E);
                  num_3     <= ~ext & (shreg == 8'h26);
                  esc       <= ~ext & (shreg == 8'h76);
                end
              end
            end else begin
              frame_error <= 1'b1;
              ext         <= 1'b0;
              brk         <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // Abandon the frame when the count of edge-free cycles reaches TIMEOUT.
        if (to_cnt == TIMEOUT_CNT - 16'd1) begin
          state       <= IDLE;
          to_cnt      <= 16'd0;
          frame_error <= 1'b1;
          ext         <= 1'b0;
          brk         <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 16'd1;
        end
      end else begin
        to_cnt <= 16'd0;
      end
    end
  end

endmodule
